d_reg_pipe: RTL and testbench



---
 rtl/d_reg_pipe_if.sv | 34 +++
 rtl/d_reg_pipe.sv | 99 +++++++++
 tb/tb_d_reg_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/d_reg_pipe_if.sv
// d_reg_pipe_if: bundles the data, valid, control and status signals of one
// d_reg_pipe instance. The master side drives data and controls. The slave
// side (the pipeline) drives the registered outputs.
interface d_reg_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();

  localparam int OCC_W = $clog2(DEPTH + 1);

  // upstream data and controls
  logic                   en;
  logic                   flush;
  logic [WIDTH-1:0]       d;
  logic                   d_valid;

  // registered pipeline status
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [WIDTH*DEPTH-1:0] taps;
  logic [DEPTH-1:0]       tap_valid;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid, taps, tap_valid, occupancy
  );

  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid, taps, tap_valid, occupancy
  );

endinterface

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: DEPTH-stage, WIDTH-bit stallable delay line. Each stage carries
// a valid bit, and a registered occupancy count tracks how many stages are valid.
// A synchronous reset or a flush loads RST_VAL into every stage and clears every
// valid bit. All state moves on one clock edge, chosen at elaboration by NEG_EDGE.
module d_reg_pipe #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter bit               NEG_EDGE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic          clk,
  input  logic          rst,
  d_reg_pipe_if.slave   bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef logic [WIDTH-1:0] word_t;

  // Reject degenerate geometries while the design is being built.
  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
    $error("d_reg_pipe: DEPTH (%0d) and WIDTH (%0d) must both be >= 1", DEPTH, WIDTH);
  end

  word_t [DEPTH-1:0] data_q, data_d;
  logic  [DEPTH-1:0] valid_q, valid_d;
  logic  [OCC_W-1:0] occ_q, occ_d;

  // Next-state: flush clears, enable shifts one stage, otherwise hold.
  always_comb begin
    // NOTE: every _d signal is defaulted to its current value before any branch,
    // so no path can leave it unassigned and no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;

    if (bus.flush) begin
      data_d  = {DEPTH{RST_VAL}};
      valid_d = '0;
      occ_d   = '0;
    end else if (bus.en) begin
      data_d[0]  = bus.d;
      valid_d[0] = bus.d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // One word may enter and one may leave on the same shift. The count only
      // moves when exactly one of the two happens.
      if (bus.d_valid && !valid_q[DEPTH-1]) begin
        occ_d = occ_q + 1'b1;
      end else if (!bus.d_valid && valid_q[DEPTH-1]) begin
        occ_d = occ_q - 1'b1;
      end
    end
  end

  // State registers. One of the two generate branches exists per instance, so
  // rising-edge and falling-edge clocking never mix.
  if (NEG_EDGE) begin : g_neg_edge
    // Falling-edge registers with synchronous reset.
    always_ff @(negedge clk) begin
      if (rst) begin
        // NOTE: the data stages are reset as well as the valids, because RST_VAL
        // is architecturally visible on q and taps right after reset.
        data_q  <= {DEPTH{RST_VAL}};
        valid_q <= '0;
        occ_q   <= '0;
      end else begin
        // NOTE: non-blocking assignments make every stage sample its
        // predecessor's pre-edge value, so the whole line shifts as one.
        data_q  <= data_d;
        valid_q <= valid_d;
        occ_q   <= occ_d;
      end
    end
  end else begin : g_pos_edge
    // Rising-edge registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= {DEPTH{RST_VAL}};
        valid_q <= '0;
        occ_q   <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        occ_q   <= occ_d;
      end
    end
  end

  // Every output is a direct register view. No logic sits between a flop and a pin.
  assign bus.q         = data_q[DEPTH-1];
  assign bus.q_valid   = valid_q[DEPTH-1];
  assign bus.taps      = data_q;
  assign bus.tap_valid = valid_q;
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe: directed bench for d_reg_pipe. The main instance is
// WIDTH=8, DEPTH=4, RST_VAL=A5, rising edge. A second instance is
// WIDTH=1, DEPTH=1, NEG_EDGE=1 and behaves as a falling-edge D flip-flop.
// Every valid word pushed in is queued, then popped and compared when it
// appears on q with q_valid set.
module tb_d_reg_pipe;

  localparam int         W  = 8;
  localparam int         D  = 4;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic rst_e;

  always #5 clk = ~clk;

  d_reg_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
  d_reg_pipe #(.WIDTH(W), .DEPTH(D), .NEG_EDGE(1'b0), .RST_VAL(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  d_reg_pipe_if #(.WIDTH(1), .DEPTH(1)) nbus ();
  d_reg_pipe #(.WIDTH(1), .DEPTH(1), .NEG_EDGE(1'b1), .RST_VAL(1'b0)) dut_neg (
    .clk (clk),
    .rst (rst_e),
    .bus (nbus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge of the main instance. Queue the word being accepted, then
  // pop-and-compare whatever the enabled shift delivers onto q.
  task automatic step();
    logic en_s, fl_s, rs_s;
    en_s = bus.en;
    fl_s = bus.flush;
    rs_s = rst;
    if (!rs_s && !fl_s && en_s && bus.d_valid) sb.push_back(bus.d);
    @(posedge clk);
    #1;
    if (rs_s || fl_s) begin
      sb.delete();
    end else if (en_s && bus.q_valid) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=%0h expected=nothing", bus.q);
      end
      if (sb.size() > 0) check("sb_q", {24'h0, bus.q}, {24'h0, sb.pop_front()});
    end
  endtask

  logic [7:0] bub_d[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic       bub_v[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic       bub_q[3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    rst          = 1'b1;
    rst_e        = 1'b1;
    bus.en       = 1'b1;
    bus.flush    = 1'b0;
    bus.d        = 8'hFF;
    bus.d_valid  = 1'b1;
    nbus.en      = 1'b1;
    nbus.flush   = 1'b0;
    nbus.d       = 1'b0;
    nbus.d_valid = 1'b1;

    // Reset wins over en and d_valid.
    step();
    step();
    check("rst_q",         bus.q,         RV);
    check("rst_q_valid",   bus.q_valid,   0);
    check("rst_tap_valid", bus.tap_valid, 0);
    check("rst_occ",       bus.occupancy, 0);
    check("rst_taps",      bus.taps,      32'hA5A5A5A5);

    // Latency and ordering: 01..04 in, each reaches q after 4 enabled edges.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.d = 8'(k + 1);
      step();
      check($sformatf("lat_occ%0d", k), bus.occupancy, k + 1);
      if (k < 3) check($sformatf("lat_qv%0d", k), bus.q_valid, 0);
    end
    check("lat_q01",  bus.q,       8'h01);
    check("lat_qv01", bus.q_valid, 1);
    bus.d_valid = 1'b0;
    bus.d       = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("drain_occ%0d", k), bus.occupancy, 3 - k);
      if (k < 3) begin
        check($sformatf("drain_q%0d", k),  bus.q,       k + 2);
        check($sformatf("drain_qv%0d", k), bus.q_valid, 1);
      end else begin
        check("drain_qv_end", bus.q_valid, 0);
      end
    end

    // Stall: fill with 10..13, hold for 5 edges while d toggles, then resume.
    bus.d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.d = 8'h10 + 8'(k);
      step();
    end
    check("fill_taps",      bus.taps,      32'h10111213);
    check("fill_tap_valid", bus.tap_valid, 4'hF);
    check("fill_occ",       bus.occupancy, 4);
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.d = ~bus.d;
      step();
      check($sformatf("stall_taps%0d", k), bus.taps,      32'h10111213);
      check($sformatf("stall_tv%0d", k),   bus.tap_valid, 4'hF);
      check($sformatf("stall_occ%0d", k),  bus.occupancy, 4);
    end
    bus.en = 1'b1;
    bus.d  = 8'h14;
    step();
    check("resume_taps", bus.taps,      32'h11121314);
    check("resume_q",    bus.q,         8'h11);
    check("resume_occ",  bus.occupancy, 4);   // one in, one out

    // Flush beats en, and the word offered with it is discarded.
    bus.flush   = 1'b1;
    bus.d       = 8'h77;
    bus.d_valid = 1'b1;
    step();
    check("flush_tap_valid", bus.tap_valid, 0);
    check("flush_occ",       bus.occupancy, 0);
    check("flush_taps",      bus.taps,      32'hA5A5A5A5);
    check("flush_q_valid",   bus.q_valid,   0);
    bus.flush = 1'b0;

    // Bubbles: valid pattern 1,0,1,1. Stage 0 holds DD, stage 3 holds AA.
    for (int k = 0; k < 4; k++) begin
      bus.d       = bub_d[k];
      bus.d_valid = bub_v[k];
      step();
    end
    check("bub_tap_valid", bus.tap_valid, 4'b1011);
    check("bub_occ",       bus.occupancy, 3);
    check("bub_q",         bus.q,         8'hAA);
    check("bub_qv0",       bus.q_valid,   1);
    bus.d_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bub_qv%0d", k + 1), bus.q_valid, bub_q[k]);
    end
    check("bub_occ_end", bus.occupancy, 1);

    // A reset mid-stream drops in-flight data. The next enabled edge loads normally.
    rst         = 1'b1;
    bus.d       = 8'h66;
    bus.d_valid = 1'b1;
    step();
    check("mrst_tap_valid", bus.tap_valid, 0);
    check("mrst_q",         bus.q,         RV);
    rst   = 1'b0;
    bus.d = 8'h5A;
    step();
    check("mrst_load_tv",   bus.tap_valid, 4'b0001);
    check("mrst_load_taps", bus.taps,      32'hA5A5A55A);
    check("mrst_load_occ",  bus.occupancy, 1);
    check("sb_left",        sb.size(),     1);

    // Falling-edge single flop: d changes at the rise are seen only at the fall.
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("neg_rst_q",   nbus.q,         0);
    check("neg_rst_qv",  nbus.q_valid,   0);
    check("neg_rst_occ", nbus.occupancy, 0);
    rst_e  = 1'b0;
    nbus.d = 1'b1;
    #1;
    check("neg_no_rise", nbus.q, 0);
    @(negedge clk);
    #1;
    check("neg_fall_q",  nbus.q,         1);
    check("neg_fall_tv", nbus.tap_valid, 1);
    @(posedge clk);
    #1;
    nbus.d = 1'b0;
    #1;
    check("neg_hold_hi", nbus.q, 1);
    @(negedge clk);
    #1;
    check("neg_fall_q0", nbus.q, 0);
    @(posedge clk);
    #1;
    nbus.d = 1'b1;
    @(negedge clk);
    #1;
    check("neg_fall_q1", nbus.q, 1);
    // A reset pulse confined to the high phase is never sampled.
    @(posedge clk);
    #1;
    rst_e = 1'b1;
    #2;
    rst_e = 1'b0;
    @(negedge clk);
    #1;
    check("neg_glitch_q",  nbus.q,       1);
    check("neg_glitch_qv", nbus.q_valid, 1);
    // A reset held across the fall takes effect.
    @(posedge clk);
    #1;
    rst_e = 1'b1;
    @(negedge clk);
    #1;
    check("neg_rst2_qv", nbus.q_valid, 0);
    check("neg_rst2_q",  nbus.q,       0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
